// File: rtl/ocs_4x4_cfg_ctrl_pkg.sv
// Shared definitions for the 4x4 optical circuit switch configuration controller.
package ocs_4x4_cfg_ctrl_pkg;

   localparam int         C_PORTS   = 4;
   localparam int         C_ELEMS   = 6;
   localparam logic [7:0] C_PERM_ID = 8'hE4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_SEARCH,
      S_PRE,
      S_SETTLE,
      S_DONE
   } state_t;

   // A permutation is only legal if every input names a different output port.
   function automatic logic perm_has_dup(input logic [2*C_PORTS-1:0] perm);
      logic dup;
      dup = 1'b0;
      for (int i = 0; i < C_PORTS; i++) begin
         for (int j = i + 1; j < C_PORTS; j++) begin
            if (perm[2*i +: 2] == perm[2*j +: 2]) dup = 1'b1;
         end
      end
      return dup;
   endfunction

   // One 2x2 element carrying port labels; result is {hi_out, lo_out}.
   function automatic logic [3:0] elem_2x2(input logic [1:0] lo, input logic [1:0] hi,
                                           input logic swap);
      return swap ? {lo, hi} : {hi, lo};
   endfunction

endpackage

// File: rtl/ocs_4x4_route_model.sv
// Combinational model of the six-element fabric: grant code -> achieved permutation.
module ocs_4x4_route_model
   import ocs_4x4_cfg_ctrl_pkg::*;
#(
   parameter logic P_BAR   = 1'b0,
   parameter logic P_CROSS = 1'b1
) (
   input  logic [C_ELEMS-1:0]   i_cand,
   output logic [2*C_PORTS-1:0] o_perm
);

   logic [C_ELEMS-1:0] w_swap;
   logic [3:0]         w_e0, w_e1, w_e2, w_e3, w_e4, w_e5;

   // An element swaps only when its grant bit carries the CROSS value.
   always_comb begin
      for (int k = 0; k < C_ELEMS; k++) begin
         w_swap[k] = (i_cand[k] == P_CROSS) && (i_cand[k] != P_BAR);
      end
   end

   // Propagate input port labels through the fabric wiring.
   assign w_e3 = elem_2x2(2'd2,      2'd3,      w_swap[3]);
   assign w_e1 = elem_2x2(2'd1,      w_e3[1:0], w_swap[1]);
   assign w_e0 = elem_2x2(2'd0,      w_e1[1:0], w_swap[0]);
   assign w_e4 = elem_2x2(w_e1[3:2], w_e3[3:2], w_swap[4]);
   assign w_e2 = elem_2x2(w_e0[3:2], w_e4[1:0], w_swap[2]);
   assign w_e5 = elem_2x2(w_e2[3:2], w_e4[3:2], w_swap[5]);

   // Invert output->label into input->output permutation format.
   // NOTE: assigning a default first keeps this combinational block latch-free.
   always_comb begin
      o_perm = '0;
      o_perm[{w_e0[1:0], 1'b0} +: 2] = 2'd0;
      o_perm[{w_e2[1:0], 1'b0} +: 2] = 2'd1;
      o_perm[{w_e5[1:0], 1'b0} +: 2] = 2'd2;
      o_perm[{w_e5[3:2], 1'b0} +: 2] = 2'd3;
   end

endmodule

// File: rtl/ocs_4x4_cfg_ctrl.sv
// Configuration controller: validates a requested permutation, searches for the
// lowest grant code realising it, and applies it inside a blanking window.
module ocs_4x4_cfg_ctrl
   import ocs_4x4_cfg_ctrl_pkg::*;
#(
   parameter logic P_BAR    = 1'b0,
   parameter logic P_CROSS  = 1'b1,
   parameter int   P_PRE    = 4,
   parameter int   P_SETTLE = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic [2*C_PORTS-1:0]   i_perm,
   output logic [C_ELEMS-1:0]     o_grant,
   output logic                   o_blank,
   output logic                   o_done,
   output logic                   o_err,
   output logic [2*C_PORTS-1:0]   o_cur_perm
);

   localparam int C_MAX_PS  = (P_PRE > P_SETTLE) ? P_PRE : P_SETTLE;
   localparam int C_CNT_MAX = (C_MAX_PS > 2**C_ELEMS) ? C_MAX_PS : 2**C_ELEMS;
   localparam int C_CNT_W   = $clog2(C_CNT_MAX);

   localparam logic [C_CNT_W-1:0] C_PRE_LAST    = C_CNT_W'(P_PRE - 1);
   localparam logic [C_CNT_W-1:0] C_SETTLE_LAST = C_CNT_W'(P_SETTLE - 1);
   localparam logic [C_CNT_W-1:0] C_CAND_LAST   = C_CNT_W'(2**C_ELEMS - 1);

   state_t                 r_state, w_state_nxt;
   logic [C_CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic [2*C_PORTS-1:0]   r_perm, w_perm_nxt;
   logic [C_ELEMS-1:0]     r_code, w_code_nxt;
   logic [C_ELEMS-1:0]     r_grant, w_grant_nxt;
   logic [2*C_PORTS-1:0]   r_cur_perm, w_cur_nxt;
   logic                   r_ready, w_ready_nxt;
   logic                   r_blank, w_blank_nxt;
   logic                   r_done, w_done_nxt;
   logic                   r_err, w_err_nxt;
   logic [2*C_PORTS-1:0]   w_route_perm;
   logic                   w_match;

   // The counter doubles as the search candidate while in SEARCH.
   ocs_4x4_route_model #(
      .P_BAR   (P_BAR),
      .P_CROSS (P_CROSS)
   ) u_route (
      .i_cand (r_cnt[C_ELEMS-1:0]),
      .o_perm (w_route_perm)
   );

   assign w_match = (w_route_perm == r_perm);

   // State and registered outputs.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_perm     <= C_PERM_ID;
         r_code     <= {C_ELEMS{P_BAR}};
         r_grant    <= {C_ELEMS{P_BAR}};
         r_cur_perm <= C_PERM_ID;
         r_ready    <= 1'b1;
         r_blank    <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_perm     <= w_perm_nxt;
         r_code     <= w_code_nxt;
         r_grant    <= w_grant_nxt;
         r_cur_perm <= w_cur_nxt;
         r_ready    <= w_ready_nxt;
         r_blank    <= w_blank_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_perm_nxt  = r_perm;
      w_code_nxt  = r_code;
      w_grant_nxt = r_grant;
      w_cur_nxt   = r_cur_perm;
      w_ready_nxt = 1'b0;
      w_blank_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_ready_nxt = 1'b1;
            w_cnt_nxt   = '0;
            if (i_req_valid && r_ready) begin
               w_perm_nxt  = i_perm;
               w_state_nxt = S_CHECK;
               w_ready_nxt = 1'b0;
            end
         end
         S_CHECK: begin
            w_cnt_nxt = '0;
            if (perm_has_dup(r_perm)) begin
               w_err_nxt   = 1'b1;
               w_ready_nxt = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_SEARCH;
            end
         end
         S_SEARCH: begin
            if (w_match) begin
               w_code_nxt  = r_cnt[C_ELEMS-1:0];
               w_cnt_nxt   = '0;
               w_blank_nxt = 1'b1;
               w_state_nxt = S_PRE;
            end else if (r_cnt == C_CAND_LAST) begin
               w_cnt_nxt   = '0;
               w_err_nxt   = 1'b1;
               w_ready_nxt = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_PRE: begin
            w_blank_nxt = 1'b1;
            if (r_cnt == C_PRE_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_SETTLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_SETTLE: begin
            if (r_cnt == C_SETTLE_LAST) begin
               w_cnt_nxt   = '0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_blank_nxt = 1'b1;
               w_cnt_nxt   = r_cnt + 1'b1;
            end
         end
         S_DONE: begin
            w_ready_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_ready_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase

      // The grant switches on the edge that opens the final PRE cycle; this also
      // covers a one-cycle PRE window entered straight from SEARCH.
      if ((w_state_nxt == S_PRE) && (w_cnt_nxt == C_PRE_LAST)) begin
         w_grant_nxt = w_code_nxt;
         w_cur_nxt   = r_perm;
      end
   end

   assign o_req_ready = r_ready;
   assign o_grant     = r_grant;
   assign o_blank     = r_blank;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_cur_perm  = r_cur_perm;

endmodule

// File: tb/tb_ocs_4x4_cfg_ctrl.sv
// Self-checking bench for ocs_4x4_cfg_ctrl against a netlist-table fabric model.
module tb_ocs_4x4_cfg_ctrl;

   localparam logic P_BAR    = 1'b0;
   localparam logic P_CROSS  = 1'b1;
   localparam int   P_PRE    = 4;
   localparam int   P_SETTLE = 16;
   localparam int   C_BUDGET = 300;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_req_valid = 1'b0;
   logic [7:0] i_perm = 8'hE4;
   logic       o_req_ready;
   logic [5:0] o_grant;
   logic       o_blank;
   logic       o_done;
   logic       o_err;
   logic [7:0] o_cur_perm;

   always #5 i_clk = ~i_clk;

   ocs_4x4_cfg_ctrl #(
      .P_BAR    (P_BAR),
      .P_CROSS  (P_CROSS),
      .P_PRE    (P_PRE),
      .P_SETTLE (P_SETTLE)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_perm      (i_perm),
      .o_grant     (o_grant),
      .o_blank     (o_blank),
      .o_done      (o_done),
      .o_err       (o_err),
      .o_cur_perm  (o_cur_perm)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Fabric netlist: nodes 0..3 are inputs, element k drives node 4+2k (lo) and 5+2k (hi).
   int elem_order [6] = '{3, 1, 0, 4, 2, 5};
   int src_lo     [6] = '{0, 1, 5, 2, 7, 9};
   int src_hi     [6] = '{6, 10, 12, 3, 11, 13};
   int out_node   [4] = '{4, 8, 14, 15};

   // Route four data bytes through the fabric under a given grant.
   function automatic logic [31:0] fabric_route(input logic [5:0] grant, input logic [31:0] data);
      logic [7:0]  node [16];
      logic [7:0]  a, b;
      logic [31:0] res;
      int          k;
      for (int i = 0; i < 16; i++) node[i] = 8'h00;
      for (int i = 0; i < 4; i++) node[i] = data[8*i +: 8];
      for (int s = 0; s < 6; s++) begin
         k = elem_order[s];
         a = node[src_lo[k]];
         b = node[src_hi[k]];
         if (grant[k] == P_CROSS) begin
            node[4+2*k] = b;
            node[5+2*k] = a;
         end else begin
            node[4+2*k] = a;
            node[5+2*k] = b;
         end
      end
      res = '0;
      for (int j = 0; j < 4; j++) res[8*j +: 8] = node[out_node[j]];
      return res;
   endfunction

   function automatic logic [7:0] achieved_perm(input logic [5:0] grant);
      logic [31:0] outs;
      logic [7:0]  p;
      int          lbl;
      outs = fabric_route(grant, {8'd3, 8'd2, 8'd1, 8'd0});
      p = '0;
      for (int j = 0; j < 4; j++) begin
         lbl = int'(outs[8*j +: 8]);
         p[2*lbl +: 2] = 2'(j);
      end
      return p;
   endfunction

   function automatic int lowest_code(input logic [7:0] perm);
      for (int c = 0; c < 64; c++) begin
         if (achieved_perm(6'(c)) == perm) return c;
      end
      return 64;
   endfunction

   function automatic bit is_perm(input logic [7:0] perm);
      bit seen [4];
      for (int i = 0; i < 4; i++) seen[i] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (seen[perm[2*i +: 2]]) return 1'b0;
         seen[perm[2*i +: 2]] = 1'b1;
      end
      return 1'b1;
   endfunction

   // Expected fabric output when input i must land on output perm[i].
   function automatic logic [31:0] expect_route(input logic [7:0] perm, input logic [31:0] data);
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) res[8*perm[2*i +: 2] +: 8] = data[8*i +: 8];
      return res;
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (!o_req_ready && w < C_BUDGET) begin
         @(negedge i_clk);
         w++;
      end
      check("ready_wait", o_req_ready, 1);
   endtask

   // Issue one request and score the whole transaction cycle by cycle.
   task automatic run_req(input logic [7:0] perm, input bit hold_valid);
      logic [5:0]  g_old, g_before, g_after;
      logic [7:0]  cur_old;
      logic [31:0] data;
      int          k, n, blank_start, blank_cnt, done_n, err_n, ready_busy;
      bit          legal;
      legal       = is_perm(perm);
      k           = legal ? lowest_code(perm) : -1;
      blank_start = -1;
      blank_cnt   = 0;
      done_n      = -1;
      err_n       = -1;
      ready_busy  = 0;
      g_before    = 'x;
      g_after     = 'x;
      wait_ready();
      g_old       = o_grant;
      cur_old     = o_cur_perm;
      i_req_valid = 1'b1;
      i_perm      = perm;
      @(negedge i_clk);
      n = 0;
      while (n < C_BUDGET) begin
         if (hold_valid) i_perm = 8'($urandom);
         else i_req_valid = 1'b0;
         if (o_blank) begin
            if (blank_start < 0) blank_start = n;
            blank_cnt++;
         end
         if (o_done && done_n < 0) done_n = n;
         if (o_err && err_n < 0) err_n = n;
         if (o_req_ready && done_n < 0 && err_n < 0) ready_busy++;
         if (n == k + P_PRE) g_before = o_grant;
         if (n == k + 1 + P_PRE) g_after = o_grant;
         if (done_n >= 0 || err_n >= 0) break;
         @(negedge i_clk);
         n++;
      end
      i_req_valid = 1'b0;
      check("ready_low_busy", ready_busy, 0);
      if (legal) begin
         check("err_none", err_n, -1);
         check("blank_start", blank_start, k + 2);
         check("blank_len", blank_cnt, P_PRE + P_SETTLE);
         check("done_at", done_n, k + 2 + P_PRE + P_SETTLE);
         check("grant_before", g_before, g_old);
         check("grant_after", g_after, k);
         @(negedge i_clk);
         check("done_pulse", o_done, 0);
         check("ready_back", o_req_ready, 1);
         check("cur_perm", o_cur_perm, perm);
         data = $urandom;
         check("fabric_route", fabric_route(o_grant, data), expect_route(perm, data));
      end else begin
         check("err_at", err_n, 1);
         check("no_blank", blank_cnt, 0);
         check("no_done", done_n, -1);
         @(negedge i_clk);
         check("err_pulse", o_err, 0);
         check("ready_back", o_req_ready, 1);
         check("grant_kept", o_grant, g_old);
         check("cur_kept", o_cur_perm, cur_old);
      end
   endtask

   // Reset asserted mid-SETTLE must abort immediately with no completion pulse.
   task automatic reset_in_settle(input logic [7:0] perm);
      int k, n, done_seen;
      k = lowest_code(perm);
      done_seen = 0;
      wait_ready();
      i_req_valid = 1'b1;
      i_perm      = perm;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      for (n = 0; n < k + P_PRE + 5; n++) @(negedge i_clk);
      check("settle_blank", o_blank, 1);
      check("settle_grant", o_grant, k);
      i_rst = 1'b1;
      #1;
      check("rst_grant", o_grant, {6{P_BAR}});
      check("rst_blank", o_blank, 0);
      check("rst_cur_perm", o_cur_perm, 8'hE4);
      check("rst_ready", o_req_ready, 1);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int c = 0; c < P_SETTLE + 10; c++) begin
         @(negedge i_clk);
         if (o_done || o_blank) done_seen++;
      end
      check("rst_no_done", done_seen, 0);
   endtask

   initial begin
      logic [7:0] perms[$];
      logic [7:0] tmp;
      int         j;

      @(negedge i_clk);
      check("reset_grant", o_grant, {6{P_BAR}});
      check("reset_cur_perm", o_cur_perm, 8'hE4);
      check("reset_ready", o_req_ready, 1);
      check("reset_blank", o_blank, 0);
      check("reset_done", o_done, 0);
      check("reset_err", o_err, 0);
      i_rst = 1'b0;
      @(negedge i_clk);

      run_req(8'hE4, 1'b0);
      run_req(8'hE1, 1'b0);
      check("e1_grant", o_grant, 6'b000001);
      run_req(8'hE0, 1'b0);

      for (int b = 0; b < 256; b++) begin
         if (is_perm(8'(b))) perms.push_back(8'(b));
      end
      check("perm_count", perms.size(), 24);
      for (int i = perms.size() - 1; i > 0; i--) begin
         j        = $urandom_range(i, 0);
         tmp      = perms[i];
         perms[i] = perms[j];
         perms[j] = tmp;
      end
      foreach (perms[i]) run_req(perms[i], 1'b1);

      for (int r = 0; r < 12; r++) run_req(8'($urandom), 1'b0);

      reset_in_settle(8'h1B);
      run_req(8'hE1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
